decade_counter_ctrl: RTL
========================

// Module: decade_counter_ctrl
// PURPOSE
//  Run/pause/clear controller for a cascade of mod-10 digit counters (stopwatch/event timer).
//  Prescales clk into count ticks, sequences the digit chain, propagates carries and
//  flags terminal count. Sits between user control pulses and display/BCD decode logic.
// PARAMETERS
//  DIGITS      4   number of cascaded BCD digits (1..8)
//  PRESCALE    10  clk cycles per count tick (>=1; 1 = tick every RUN cycle)
//  STOP_AT_MAX 0   1: halt in DONE at all-9s; 0: wrap to all-0s and pulse overflow
// PORTS
//  clk       in   1          rising-edge clock
//  reset_n   in   1          asynchronous, active-low reset
//  start     in   1          level/pulse; request RUN
//  stop      in   1          level/pulse; request PAUSE
//  clear     in   1          synchronous clear to IDLE, digits 0
//  digits    out  4*DIGITS   BCD value, digit 0 = bits [3:0] (least significant)
//  running   out  1          1 while state == RUN
//  done      out  1          1 while state == DONE (only reachable when STOP_AT_MAX=1)
//  overflow  out  1          1-cycle pulse on wrap from all-9s to all-0s (STOP_AT_MAX=0)
// BEHAVIOUR
//  Reset: state IDLE, digits 0, prescaler 0, running 0, done 0, overflow 0.
//  FSM IDLE/RUN/PAUSE/DONE; priority per cycle: clear > stop > start.
//   clear (any state) -> IDLE; digits, prescaler cleared on same edge.
//   IDLE  + start -> RUN (prescaler 0).  PAUSE + start -> RUN (prescaler resumes held value).
//   RUN   + stop  -> PAUSE; digits and prescaler hold. start&stop together -> stop wins.
//   DONE  ignores start/stop; only clear or reset leaves it.
//  Prescaler counts 0..PRESCALE-1 only in RUN; tick = RUN && presc==PRESCALE-1, presc->0.
//  Latency: start sampled at edge k -> running=1 after k; first increment at edge k+PRESCALE.
//  Digit i increments on tick when digits 0..i-1 all ==9; digit at 9 with carry-in -> 0.
//  Terminal: tick with all digits ==9:
//   STOP_AT_MAX=1 -> digits hold 9..9, state DONE, running 0, done 1.
//   STOP_AT_MAX=0 -> digits 0..0, overflow=1 for exactly one cycle, stay RUN.
//  A digit never leaves 0..9; any tick in a non-RUN state is impossible by construction.
//  Reset_n assertion mid-count: all state cleared asynchronously, no completion.
//  All outputs registered; no combinational input->output path.
// CONFIGURATION
//  `LAP_EN defined: adds ports lap (in,1) and lap_q (out,4*DIGITS).
//   lap=1 in RUN or PAUSE copies current digits to lap_q on that edge; counting unaffected.
//   clear and reset zero lap_q; lap in IDLE/DONE ignored.
//  `LAP_EN undefined: ports lap/lap_q absent, no lap register.
// STRUCTURE
//  Package decade_ctrl_pkg: state encoding IDLE=2'b00 RUN=2'b01 PAUSE=2'b10 DONE=2'b11,
//   BCD_MAX=4'd9, digit width constant 4.
//  Sub-module bcd_digit: one mod-10 digit with en/clr, outputs value and carry (value==9).
//   Instantiated DIGITS times via generate; carry chain ANDed with tick in controller.
// TESTING (DIGITS=2, PRESCALE=3 unless stated)
//  1 reset_n low mid-RUN at digits=8'h47 -> digits=0, running=0, done=0 immediately.
//  2 start 1 cycle from IDLE -> running=1; digits 00->01 after 3 cycles, 02 after 6.
//  3 RUN at 8'h09, tick -> 8'h10; at 8'h19 -> 8'h20 (carry chain check).
//  4 stop at 8'h05 mid-prescale, wait 20 cycles -> 8'h05 held; start -> 8'h06 after remaining presc.
//  5 STOP_AT_MAX=0 at 8'h99, tick -> 8'h00, overflow high 1 cycle; STOP_AT_MAX=1 -> holds 99, done=1, start ignored.
//  6 start+stop+clear same cycle in RUN at 8'h33 -> IDLE, 8'h00; LAP_EN: lap at 8'h12 -> lap_q=8'h12.

Source files
------------

// File: rtl/decade_ctrl_pkg.sv
// Shared state encoding and BCD constants for the decade counter controller.
package decade_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] v);
    return (v == BCD_MAX) ? '0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One mod-10 digit: synchronous clear, increment on en, wraps 9 -> 0.
module bcd_digit
  import decade_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               en,
  output logic [DIGIT_W-1:0] value,
  output logic               carry
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en) begin
      value <= bcd_inc(value);
    end
  end

  assign carry = (value == BCD_MAX);

endmodule

// File: rtl/decade_counter_ctrl.sv
// Run/pause/clear controller for a cascade of BCD digits with prescaled count ticks.
// Optional lap capture register is built when LAP_EN is defined.
module decade_counter_ctrl
  import decade_ctrl_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int PRESCALE    = 10,
  parameter int STOP_AT_MAX = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        clear,
`ifdef LAP_EN
  input  logic                        lap,
  output logic [DIGIT_W*DIGITS-1:0]   lap_q,
`endif
  output logic [DIGIT_W*DIGITS-1:0]   digits,
  output logic                        running,
  output logic                        done,
  output logic                        overflow
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  state_t            state;
  logic [PW-1:0]     presc;
  logic [DIGITS-1:0] carry;
  logic [DIGITS:0]   chain;
  logic              tick;
  logic              hold_max;

  // A stop or clear on the tick cycle wins, so no increment happens then.
  assign tick     = (state == RUN) && !clear && !stop && (presc == PRESC_LAST);
  assign hold_max = (STOP_AT_MAX != 0) && (&carry);
  assign chain[0] = tick && !hold_max;

  // chain[i] enables digit i; chain[DIGITS] marks the all-9s wrap.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign chain[i+1] = chain[i] & carry[i];

    bcd_digit u_digit (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clear),
      .en      (chain[i]),
      .value   (digits[i*DIGIT_W +: DIGIT_W]),
      .carry   (carry[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      presc    <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= chain[DIGITS];
      if (clear) begin
        state   <= IDLE;
        presc   <= '0;
        running <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              state   <= RUN;
              presc   <= '0;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (stop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else if (presc == PRESC_LAST) begin
              presc <= '0;
              if (hold_max) begin
                state   <= DONE;
                running <= 1'b0;
                done    <= 1'b1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          PAUSE: begin
            if (start && !stop) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef LAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_q <= '0;
    end else if (clear) begin
      lap_q <= '0;
    end else if (lap && (state == RUN || state == PAUSE)) begin
      lap_q <= digits;
    end
  end
`endif

endmodule
